bist_resp_monitor: RTL and testbench

Response monitor that sits directly downstream of the LBIST comparator. It samples the comparator's 1-bit mismatch result once per applied test pattern over a fixed-length run, and counts mismatches. It also captures the index of the first failing pattern and reports a final pass/fail verdict to the BIST controller through a start/done handshake.

---
 rtl/bist_pkg.sv | 9 +
 rtl/sat_counter.sv | 20 ++
 rtl/bist_resp_monitor.sv | 61 ++++++
 tb/tb_bist_resp_monitor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared LBIST constants and response-monitor state encoding
package bist_pkg;
  localparam int DEF_PATTERNS = 16;
  localparam int DEF_CNT_BITS = 8;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear, enable and saturation at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/bist_resp_monitor.sv
// bist_resp_monitor: counts LBIST comparator mismatches per run and reports first failure and verdict
module bist_resp_monitor
  import bist_pkg::*;
#(
  parameter int PATTERNS = DEF_PATTERNS,
  parameter int CNT_BITS = DEF_CNT_BITS,
  localparam int IDX_BITS = $clog2(PATTERNS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                res_valid,
  input  logic                res,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail_seen,
  output logic [CNT_BITS-1:0] err_count,
  output logic [IDX_BITS-1:0] first_fail
);
  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [IDX_BITS-1:0] first_fail_q, first_fail_d;
  logic                fail_seen_q, fail_seen_d;
  logic                launch, sample, last;
  // start only launches from IDLE or DONE; a mid-run start is ignored
  assign launch = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign sample = (state_q == ST_RUN) && res_valid;
  assign last   = idx_q == IDX_BITS'(PATTERNS - 1);
  always_comb begin
    state_d      = launch ? ST_RUN : (sample && last) ? ST_DONE : state_q;
    idx_d        = launch ? '0 : (sample && !last) ? idx_q + 1'b1 : idx_q;
    fail_seen_d  = launch ? 1'b0 : (sample && res) ? 1'b1 : fail_seen_q;
    first_fail_d = launch ? '0 : (sample && res && !fail_seen_q) ? idx_q : first_fail_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fail_seen_q  <= fail_seen_d;
      first_fail_q <= first_fail_d;
    end
  end
  sat_counter #(.W(CNT_BITS)) u_err (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .en  (sample && res),
    .cnt (err_count)
  );
  assign busy       = state_q == ST_RUN;
  assign done       = state_q == ST_DONE;
  assign pass       = done && (err_count == '0);
  assign fail_seen  = fail_seen_q;
  assign first_fail = first_fail_q;
endmodule

// File: tb/tb_bist_resp_monitor.sv
// tb_bist_resp_monitor: randomized self-checking bench with a run-level reference model
module tb_bist_resp_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       res_valid = 1'b0;
  logic       res = 1'b0;
  logic       busy, done, pass, fail_seen;
  logic [7:0] err_count;
  logic [3:0] first_fail;
  logic       busy_s, done_s, pass_s, fail_seen_s;
  logic [1:0] err_count_s;
  logic [3:0] first_fail_s;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bist_resp_monitor #(.PATTERNS(16), .CNT_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res(res),
    .busy(busy), .done(done), .pass(pass), .fail_seen(fail_seen),
    .err_count(err_count), .first_fail(first_fail)
  );

  bist_resp_monitor #(.PATTERNS(16), .CNT_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res(res),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail_seen(fail_seen_s),
    .err_count(err_count_s), .first_fail(first_fail_s)
  );

  function automatic int sat(input int n, input int m);
    return n > m ? m : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full run from the given mismatch map; the model is just a running
  // mismatch tally and the lowest mismatching pattern number.
  task automatic do_run(input logic [15:0] mism, input int gap_max, input bit noise, input string tag);
    int n = 0;
    int first = -1;
    int g;
    res_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err_count !== 8'd0 || fail_seen !== 1'b0 ||
        first_fail !== 4'd0 || busy_s !== 1'b1 || err_count_s !== 2'd0 || fail_seen_s !== 1'b0) begin
      errors++;
      $display("FAIL %s_launch: busy=%b done=%b pass=%b err=%0d fs=%b ff=%0d err_s=%0d fs_s=%b, required busy=1 rest 0",
               tag, busy, done, pass, err_count, fail_seen, first_fail, err_count_s, fail_seen_s);
    end
    for (int i = 0; i < 16; i++) begin
      g = gap_max > 0 ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        res_valid = 1'b0;
        res = 1'($urandom);
        start = noise ? 1'($urandom) : 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || err_count !== 8'(sat(n, 255)) || err_count_s !== 2'(sat(n, 3))) begin
          errors++;
          $display("FAIL %s_gap%0d: busy=%b done=%b err=%0d err_s=%0d, required busy=1 done=0 err=%0d err_s=%0d",
                   tag, i, busy, done, err_count, err_count_s, sat(n, 255), sat(n, 3));
        end
      end
      res_valid = 1'b1;
      res = mism[i];
      start = noise ? 1'($urandom) : 1'b0;
      tick();
      if (mism[i]) begin
        n++;
        if (first < 0) first = i;
      end
      checks++;
      if (err_count !== 8'(sat(n, 255)) || err_count_s !== 2'(sat(n, 3)) ||
          fail_seen !== (first >= 0) || fail_seen_s !== (first >= 0) ||
          (first >= 0 && (first_fail !== 4'(first) || first_fail_s !== 4'(first))) ||
          busy !== (i < 15) || done !== (i == 15) || busy_s !== (i < 15) || done_s !== (i == 15)) begin
        errors++;
        $display("FAIL %s_pat%0d: err=%0d err_s=%0d fs=%b ff=%0d ff_s=%0d busy=%b done=%b, required err=%0d err_s=%0d first=%0d busy=%b done=%b",
                 tag, i, err_count, err_count_s, fail_seen, first_fail, first_fail_s, busy, done,
                 sat(n, 255), sat(n, 3), first, i < 15, i == 15);
      end
    end
    start = 1'b0;
    repeat (3) begin
      res_valid = 1'($urandom);
      res = 1'($urandom);
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== (n == 0) || pass_s !== (n == 0) ||
          err_count !== 8'(sat(n, 255)) || err_count_s !== 2'(sat(n, 3)) ||
          fail_seen !== (n > 0) || (n > 0 && first_fail !== 4'(first)) || done_s !== 1'b1) begin
        errors++;
        $display("FAIL %s_hold: done=%b busy=%b pass=%b pass_s=%b err=%0d err_s=%0d fs=%b ff=%0d, required done=1 pass=%b err=%0d err_s=%0d first=%0d",
                 tag, done, busy, pass, pass_s, err_count, err_count_s, fail_seen, first_fail,
                 n == 0, sat(n, 255), sat(n, 3), first);
      end
    end
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail_seen !== 1'b0 || err_count !== 8'd0 ||
        first_fail !== 4'd0 || busy_s !== 1'b0 || err_count_s !== 2'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b pass=%b fs=%b err=%0d ff=%0d, required all 0",
               busy, done, pass, fail_seen, err_count, first_fail);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_abort();
    logic [4:0] pat = 5'b01010;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1;
      res = pat[i];
      tick();
    end
    res_valid = 1'b0;
    checks++;
    if (err_count !== 8'd2 || fail_seen !== 1'b1 || first_fail !== 4'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: err=%0d fs=%b ff=%0d busy=%b, required 2 1 1 1", err_count, fail_seen, first_fail, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail_seen !== 1'b0 || err_count !== 8'd0 ||
        first_fail !== 4'd0 || err_count_s !== 2'd0 || fail_seen_s !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst: busy=%b done=%b pass=%b fs=%b err=%0d ff=%0d, required all 0",
               busy, done, pass, fail_seen, err_count, first_fail);
    end
    res_valid = 1'b1;
    res = 1'b1;
    tick();
    res_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || err_count !== 8'd0 || fail_seen !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_res: busy=%b err=%0d fs=%b, required 0 0 0", busy, err_count, fail_seen);
    end
  endtask

  task automatic test_all_match();
    do_run(16'h0000, 0, 1'b0, "all_match");
  endtask

  task automatic test_mismatches();
    do_run(16'h8088, 0, 1'b0, "mism_3_7_15");
  endtask

  task automatic test_gaps_noise();
    do_run(16'h0421, 4, 1'b1, "gaps_noise");
  endtask

  task automatic test_saturation();
    do_run(16'hFFFF, 0, 1'b0, "saturate");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) do_run(16'($urandom), 0, 1'b0, "b2b_rand");
    do_run(16'h0000, 0, 1'b0, "b2b_clean");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) do_run(16'($urandom), 3, 1'b1, "rand_gaps");
  endtask

  initial begin
    test_reset();
    test_abort();
    test_all_match();
    test_mismatches();
    test_gaps_noise();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
